// File: rtl/game_pkg.sv
// Shared encodings for the sliding-block game: board status, one-hot move codes
// and the BCD helpers used by the control counters.
package game_pkg;

  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAMING       = 2'b01,
    GAME_INITIAL = 2'b10,
    WINNED       = 2'b11
  } game_status_t;

  localparam logic [3:0] ACT_LEFT  = 4'b1000;
  localparam logic [3:0] ACT_DOWN  = 4'b0100;
  localparam logic [3:0] ACT_RIGHT = 4'b0010;
  localparam logic [3:0] ACT_UP    = 4'b0001;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v >= 8'h99) return v;
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bin2bcd(input int v);
    int c;
    c = (v > 99) ? 99 : v;
    return {4'(c / 10), 4'(c % 10)};
  endfunction

endpackage

// File: rtl/bcd_cnt2.sv
// Two-digit BCD counter with synchronous clear and increment, saturating at 99.
module bcd_cnt2
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= bcd_inc(cnt);
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: conditions button/switch inputs, walks the board through
// selection, initial placement, play and finish, and keeps move/second counts.
module game_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int TIME_LIMIT = 60,
  parameter int SETTLE     = 3
) (
  input  logic        clk_d,
  input  logic        rst,
  input  logic [3:0]  btn,
  input  logic        start,
  input  logic        restart,
  input  logic        ini_flag,
  input  logic        win_flag,
  input  logic [11:0] out_game,
  output logic [1:0]  game_status,
  output logic [3:0]  act,
  output logic [7:0]  move_cnt,
  output logic [7:0]  sec_cnt,
  output logic        timeout,
  output logic        busy
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [PW-1:0] PRE_LAST    = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [7:0]    LIMIT_BCD   = bin2bcd(TIME_LIMIT);

  logic [5:0]   raw_p0, raw_p1, raw_p2, rise;
  logic [3:0]   btn_rise, act_code;
  logic         start_rise, restart_rise;
  game_status_t state, state_nx;
  logic         win_hit, time_hit, time_up, stay_play, issue, accept, tick;
  logic         init_min, ini_seen;
  logic [PW-1:0] pre;
  logic [SW-1:0] settle_cnt;
  logic [11:0]  snap;

  // Stage p0/p1: two-flop synchroniser; p2 holds the previous level for edge detection
  always_ff @(posedge clk_d) begin
    if (!rst) begin
      raw_p0 <= '0;
      raw_p1 <= '0;
      raw_p2 <= '0;
    end else begin
      raw_p0 <= {restart, start, btn};
      raw_p1 <= raw_p0;
      raw_p2 <= raw_p1;
    end
  end

  assign rise         = raw_p1 & ~raw_p2;
  assign btn_rise     = rise[3:0];
  assign start_rise   = rise[4];
  assign restart_rise = rise[5];

  assign time_up = (TIME_LIMIT != 0) && (sec_cnt == LIMIT_BCD);

  always_ff @(posedge clk_d) begin
    if (!rst) state <= CHOSE_BOARD;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    win_hit  = 1'b0;
    time_hit = 1'b0;
    case (state)
      CHOSE_BOARD:  if (start_rise && !restart_rise) state_nx = GAME_INITIAL;
      GAME_INITIAL: begin
        if (restart_rise)                          state_nx = CHOSE_BOARD;
        else if (init_min && (ini_flag || ini_seen)) state_nx = GAMING;
      end
      GAMING: begin
        if (restart_rise) begin
          state_nx = CHOSE_BOARD;
        end else if (!busy && win_flag) begin
          state_nx = WINNED;
          win_hit  = 1'b1;
        end else if (time_up) begin
          state_nx = WINNED;
          time_hit = 1'b1;
        end
      end
      default:      if (restart_rise) state_nx = CHOSE_BOARD;
    endcase
  end

  // Button bits already line up with the act codes; anything not one-hot is dropped.
  always_comb begin
    case (btn_rise)
      ACT_LEFT, ACT_DOWN, ACT_RIGHT, ACT_UP: act_code = btn_rise;
      default:                               act_code = '0;
    endcase
  end

  assign stay_play = (state == GAMING) && (state_nx == GAMING);
  assign issue     = stay_play && !busy && (act_code != '0);
  assign accept    = stay_play && busy && (settle_cnt == SETTLE_LAST) && (out_game != snap);
  assign tick      = stay_play && (pre == PRE_LAST);

  always_ff @(posedge clk_d) begin
    if (!rst) begin
      init_min <= 1'b0;
      ini_seen <= 1'b0;
    end else if (state != GAME_INITIAL) begin
      init_min <= 1'b0;
      ini_seen <= 1'b0;
    end else begin
      init_min <= 1'b1;
      ini_seen <= ini_seen | ini_flag;
    end
  end

  // Stage: move issue and settle window
  always_ff @(posedge clk_d) begin
    if (!rst) begin
      act        <= '0;
      busy       <= 1'b0;
      settle_cnt <= '0;
    end else begin
      act <= issue ? act_code : '0;
      if (!stay_play) begin
        busy       <= 1'b0;
        settle_cnt <= '0;
      end else if (issue) begin
        busy       <= 1'b1;
        settle_cnt <= '0;
      end else if (busy) begin
        if (settle_cnt == SETTLE_LAST) begin
          busy       <= 1'b0;
          settle_cnt <= '0;
        end else begin
          settle_cnt <= settle_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_d) begin
    if (issue) snap <= out_game;
  end

  always_ff @(posedge clk_d) begin
    if (!rst)                  pre <= '0;
    else if (!stay_play || tick) pre <= '0;
    else                       pre <= pre + 1'b1;
  end

  always_ff @(posedge clk_d) begin
    if (!rst)                          timeout <= 1'b0;
    else if (state_nx == CHOSE_BOARD)  timeout <= 1'b0;
    else if (time_hit)                 timeout <= 1'b1;
    else if (win_hit)                  timeout <= 1'b0;
  end

  bcd_cnt2 u_move_cnt (
    .clk (clk_d),
    .rst (rst),
    .clr (state_nx == CHOSE_BOARD),
    .inc (accept),
    .cnt (move_cnt)
  );

  bcd_cnt2 u_sec_cnt (
    .clk (clk_d),
    .rst (rst),
    .clr (state_nx == CHOSE_BOARD),
    .inc (tick),
    .cnt (sec_cnt)
  );

  assign game_status = state;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomised bench for game_ctrl against an integer-level model of the game rules.
module tb_game_ctrl;

  localparam int TICK_DIV   = 24;
  localparam int TIME_LIMIT = 99;
  localparam int SETTLE     = 3;

  logic        clk_d = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  btn = '0;
  logic        start = 1'b0, restart = 1'b0, ini_flag = 1'b0, win_flag = 1'b0;
  logic [11:0] out_game = 12'h123;
  logic [1:0]  game_status;
  logic [3:0]  act;
  logic [7:0]  move_cnt, sec_cnt;
  logic        timeout, busy;

  game_ctrl #(.TICK_DIV(TICK_DIV), .TIME_LIMIT(TIME_LIMIT), .SETTLE(SETTLE)) dut (
    .clk_d(clk_d), .rst(rst), .btn(btn), .start(start), .restart(restart),
    .ini_flag(ini_flag), .win_flag(win_flag), .out_game(out_game),
    .game_status(game_status), .act(act), .move_cnt(move_cnt), .sec_cnt(sec_cnt),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk_d = ~clk_d;

  int n_vec = 0, n_err = 0;

  // Reference model: phase 0=select 1=init 2=play 3=done, plain integer counters
  int          m_phase, m_init_cyc, m_busy_left, m_moves, m_secs, m_pre;
  bit          m_ini_seen, m_tout;
  logic [11:0] m_snap;
  logic [3:0]  m_act;
  logic [5:0]  m_h0, m_h1, m_h2;

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int status_code(input int ph);
    case (ph)
      0:       return 0;
      1:       return 2;
      2:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_moves = 0; m_secs = 0; m_tout = 0; m_busy_left = 0; m_pre = 0;
  endtask

  task automatic model_step();
    logic [5:0] e;
    logic [3:0] be;
    bit se, re;
    m_act = '0;
    if (!rst) begin
      m_phase = 0;
      model_clear();
      m_h0 = '0; m_h1 = '0; m_h2 = '0;
    end else begin
      e  = m_h1 & ~m_h2;
      m_h2 = m_h1; m_h1 = m_h0; m_h0 = {restart, start, btn};
      be = e[3:0]; se = e[4]; re = e[5];
      case (m_phase)
        0: if (!re && se) begin m_phase = 1; m_init_cyc = 0; m_ini_seen = 0; end
        1: begin
          if (re) begin m_phase = 0; model_clear(); end
          else begin
            m_ini_seen = m_ini_seen | ini_flag;
            m_init_cyc++;
            if (m_init_cyc >= 2 && m_ini_seen) begin m_phase = 2; m_pre = 0; end
          end
        end
        2: begin
          if (re) begin
            m_phase = 0; model_clear();
          end else if (m_busy_left == 0 && win_flag) begin
            m_phase = 3; m_tout = 0;
          end else if (TIME_LIMIT != 0 && m_secs == TIME_LIMIT) begin
            m_phase = 3; m_tout = 1; m_busy_left = 0;
          end else begin
            m_pre++;
            if (m_pre == TICK_DIV) begin
              m_pre = 0;
              if (m_secs < 99) m_secs++;
            end
            if (m_busy_left > 0) begin
              m_busy_left--;
              if (m_busy_left == 0 && out_game != m_snap && m_moves < 99) m_moves++;
            end else if ($countones(be) == 1) begin
              m_act = be; m_snap = out_game; m_busy_left = SETTLE;
            end
          end
        end
        default: if (re) begin m_phase = 0; model_clear(); end
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_d);
    #1;
    chk_eq("game_status", game_status, status_code(m_phase));
    chk_eq("act", act, m_act);
    chk_eq("move_cnt", move_cnt, to_bcd(m_moves));
    chk_eq("sec_cnt", sec_cnt, to_bcd(m_secs));
    chk_eq("timeout", timeout, m_tout);
    chk_eq("busy", busy, m_busy_left > 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_restart();
    restart = 1'b1; tick(); tick(); restart = 1'b0; run(4);
  endtask

  task automatic begin_game();
    int n;
    start = 1'b1; tick(); tick(); start = 1'b0;
    n = 0;
    while (m_phase != 2 && n < 40) begin tick(); n++; end
    chk_eq("reach_play", m_phase, 2);
  endtask

  task automatic press(input logic [3:0] b);
    btn = b; tick(); btn = '0;
  endtask

  task automatic play_random(input int max_cyc, input int target, input bit hold_extra);
    int r, extra;
    logic [11:0] d;
    extra = 0;
    for (int i = 0; i < max_cyc && m_phase == 2; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      btn = 4'b0001 << $urandom_range(0, 3);
      else if (r < 6) btn = 4'($urandom);
      else            btn = '0;
      if (m_busy_left == SETTLE && $urandom_range(0, 7) != 0) begin
        d = 12'($urandom);
        if (d == '0) d = 12'h001;
        out_game = out_game ^ d;
      end
      tick();
      if (m_moves >= target) begin
        if (!hold_extra || extra >= 40) break;
        extra++;
      end
    end
    btn = '0;
  endtask

  initial begin
    int n;
    rst = 1'b0; tick(); tick();
    rst = 1'b1; tick();
    ini_flag = 1'b1;
    begin_game();

    // accepted move, rejected move, double edge, edge dropped while busy
    press(4'b0010); run(2); out_game = out_game ^ 12'h00f; run(4);
    press(4'b1000); run(6);
    press(4'b0101); run(6);
    press(4'b0010); run(2); press(4'b0001); run(6);
    chk_eq("first_moves", move_cnt, 8'h01);

    play_random(2000, 99, 1'b1);
    chk_eq("move_sat", move_cnt, 8'h99);

    n = 0;
    while (m_phase == 2 && n < 3000) begin tick(); n++; end
    chk_eq("timeout_flag", timeout, 1);
    for (int i = 0; i < 20; i++) begin btn = 4'($urandom); tick(); end
    btn = '0;
    pulse_restart();

    // late ini_flag, then restart mid play
    ini_flag = 1'b0;
    start = 1'b1; tick(); tick(); start = 1'b0; run(6);
    ini_flag = 1'b1; run(4);
    play_random(300, 5, 1'b0);
    pulse_restart();
    chk_eq("restart_clr", move_cnt, 0);

    // simultaneous start and restart in select
    start = 1'b1; restart = 1'b1; tick(); tick(); start = 1'b0; restart = 1'b0; run(5);
    begin_game();
    play_random(40, 99, 1'b0);
    win_flag = 1'b1;
    for (int i = 0; i < 20 && m_phase == 2; i++) begin btn = 4'b0001 << (i % 4); tick(); btn = '0; end
    win_flag = 1'b0;
    for (int i = 0; i < 15; i++) begin btn = 4'($urandom); tick(); end
    btn = '0;
    pulse_restart();

    // win and time limit in the same cycle
    begin_game();
    n = 0;
    while (m_phase == 2 && m_secs != TIME_LIMIT && n < 3000) begin tick(); n++; end
    win_flag = 1'b1; tick(); win_flag = 1'b0; run(3);
    chk_eq("win_priority", timeout, 0);
    pulse_restart();

    // reset in the middle of a game
    begin_game();
    play_random(40, 99, 1'b0);
    rst = 1'b0; tick(); rst = 1'b1; run(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
